// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Streams 32-bit instruction words into a byte-wide instruction memory,
//   one little-endian byte per cycle starting at byte address 0. Tracks the
//   number of completed bytes, raises a sticky done flag after the word
//   marked last, and a sticky error flag when a word would run past the
//   memory depth.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   instr_i               instruction word
//   instr_last_i          marks instr_i as the final word (sampled at accept)
//   instr_valid_i         producer has a word
//   instr_ready_o         loader can accept a word this cycle
//   mem_we_o              byte write enable
//   mem_addr_o            byte write address
//   mem_data_o            byte write data
//   prog_bytes_o          bytes of completed words written so far
//   done_o                last word fully written (sticky)
//   error_o               overflow detected (sticky)
module instr_mem_loader #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int MAX_LINES  = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INSTR_SIZE-1:0] instr_i,
  input  logic                  instr_last_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  output logic                  mem_we_o,
  output logic [PC_SIZE-1:0]    mem_addr_o,
  output logic [7:0]            mem_data_o,
  output logic [PC_SIZE-1:0]    prog_bytes_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE, ERROR} state_t;

  localparam logic [PC_SIZE:0] LAST_ADDR = (PC_SIZE+1)'(MAX_LINES - 1);

  state_t                  state;
  logic [1:0]              k;
  logic [INSTR_SIZE-1:0]   word_q;
  logic                    last_q;
  logic [PC_SIZE-1:0]      wr_ptr;
  logic [PC_SIZE-1:0]      prog_bytes;

  logic                    accept;
  logic                    word_end;
  logic [PC_SIZE:0]        next_base;

  // Extra MSB keeps base+3 from wrapping near the top of the address space.
  function automatic logic overflows(input logic [PC_SIZE:0] base);
    return (base + (PC_SIZE+1)'(3)) > LAST_ADDR;
  endfunction

  assign instr_ready_o = (state == IDLE) ||
                         ((state == WRITE) && (k == 2'd3) && !last_q);
  assign accept        = instr_valid_i && instr_ready_o;
  assign word_end      = (state == WRITE) && (k == 2'd3);

  // A word accepted on the final byte edge lands after the word just
  // finished, so its bounds check must use the advanced pointer.
  assign next_base = word_end ? ({1'b0, wr_ptr} + (PC_SIZE+1)'(4))
                              : {1'b0, wr_ptr};

  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = wr_ptr;
    mem_data_o = 8'h00;
    if (state == WRITE) begin
      mem_we_o   = 1'b1;
      mem_addr_o = wr_ptr + PC_SIZE'(k);
      mem_data_o = word_q[{k, 3'b000} +: 8];
    end
  end

  assign prog_bytes_o = prog_bytes;
  assign done_o       = (state == DONE);
  assign error_o      = (state == ERROR);

  // Word buffer is pure data: it is only meaningful in WRITE, which is
  // always entered through an accept, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept) word_q <= instr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      k          <= 2'd0;
      last_q     <= 1'b0;
      wr_ptr     <= '0;
      prog_bytes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (overflows(next_base)) begin
              state <= ERROR;
            end else begin
              state  <= WRITE;
              k      <= 2'd0;
              last_q <= instr_last_i;
            end
          end
        end
        WRITE: begin
          k <= k + 2'd1;
          if (k == 2'd3) begin
            wr_ptr     <= wr_ptr + PC_SIZE'(4);
            prog_bytes <= prog_bytes + PC_SIZE'(4);
            if (last_q) begin
              state <= DONE;
            end else if (accept) begin
              if (overflows(next_base)) begin
                state <= ERROR;
              end else begin
                k      <= 2'd0;
                last_q <= instr_last_i;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE:    state <= DONE;
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writes a program into the byte-wide instruction memory that the fetch side reads. Accepts 32-bit instruction words over a valid/ready stream and emits one byte write per cycle, little-endian and byte-addressed from address 0. A word at byte address A therefore reads back as {mem[A+3], mem[A+2], mem[A+1], mem[A]}. Tracks the program length, signals completion on the last word, and flags overflow past memory depth.

## Interface

**Parameters**
- PC_SIZE, 32: width of byte addresses and of the length counter.
- INSTR_SIZE, 32: instruction word width. Fixed at 4 bytes; other values are unsupported.
- MAX_LINES, 4096: instruction memory depth in bytes.

**Ports**
- clk_i, input, 1: clock. All state changes on the rising edge.
- rst_i, input, 1: reset. Synchronous, active-high.
- instr_i, input, INSTR_SIZE: instruction word to store.
- instr_last_i, input, 1: marks instr_i as the final word. Sampled with the handshake.
- instr_valid_i, input, 1: producer has a word on instr_i.
- instr_ready_o, output, 1: loader can accept a word this cycle.
- mem_we_o, output, 1: byte write enable.
- mem_addr_o, output, PC_SIZE: byte write address.
- mem_data_o, output, 8: byte write data.
- prog_bytes_o, output, PC_SIZE: number of bytes written so far.
- done_o, output, 1: last word fully written. Sticky.
- error_o, output, 1: overflow detected. Sticky.

## Operation

**States:** IDLE, WRITE, DONE, ERROR.
- Registers: byte index k (0..3), word buffer, last flag, write pointer wr_ptr.

**Handshake**
- A word transfers on a rising edge where instr_valid_i=1 and instr_ready_o=1.
- instr_ready_o is combinational from state: 1 in IDLE, 1 in WRITE when k=3 and the last flag is 0, otherwise 0.
- instr_ready_o never depends on instr_valid_i.

**Overflow check (at accept)**
- If wr_ptr+3 > MAX_LINES-1, the word is consumed but not written. The next state is ERROR.
- Compute wr_ptr+3 at PC_SIZE+1 bits so it cannot wrap.

**IDLE**
- On accept without overflow: latch the word and the last flag, set k=0, go to WRITE.

**WRITE**
- Each cycle: mem_we_o=1, mem_addr_o=wr_ptr+k, mem_data_o=word[8k+7:8k].
- On each edge: k increments.
- At the k=3 edge:
  - wr_ptr += 4 and prog_bytes_o += 4.
  - If the last flag is set, go to DONE.
  - Else, if a new word is accepted on that same edge, apply the overflow check. Without overflow, stay in WRITE with k=0 and the new word latched; otherwise go to ERROR.
  - Else go to IDLE.

**DONE and ERROR**
- Terminal until reset.
- instr_ready_o=0 and mem_we_o=0.
- done_o=1 only in DONE; error_o=1 only in ERROR.

**Outputs outside WRITE**
- mem_we_o=0, mem_addr_o=wr_ptr, mem_data_o=0.

**Reset, including mid-word**
- State returns to IDLE; k=0, wr_ptr=0, prog_bytes_o=0, done_o=0, error_o=0.
- instr_ready_o=1 from the first cycle after reset.
- A partially written word is abandoned. Bytes already written stay in memory and are not rewritten.

**prog_bytes_o**
- Counts only completed words. It never includes a partial word.

## Timing

- **Accept to first write:** word accepted at edge E drives mem_we_o=1 during the cycles after edges E, E+1, E+2 and E+3. Memory captures the bytes at edges E+1 through E+4.
- **Completion:** prog_bytes_o updates at edge E+4. For a last word, done_o rises at E+4.
- **Throughput:** back-to-back words stream at one word per 4 cycles, with mem_we_o continuously high. A gap in instr_valid_i costs at least one IDLE cycle.
- **Overflow:** error_o rises at the accepting edge.
- **Reset priority:** rst_i overrides all transitions on the same edge.

## Test plan

- **Reset values:** assert rst_i for 2 cycles. Then instr_ready_o=1, mem_we_o=0, prog_bytes_o=0, done_o=0, error_o=0.
- **Single last word:** instr_i=32'h00500093 with last=1. Writes are (0,93), (1,00), (2,50), (3,00) on 4 consecutive cycles. Then done_o=1, prog_bytes_o=4, instr_ready_o=0.
- **Back-to-back stream:**
  - Stimulus: valid held high for 3 words 32'h11223344, 32'hAABBCCDD, 32'h00000013, the last with last=1.
  - Response: 12 contiguous writes at addresses 0..11, the first four being 44,33,22,11, with no gap in mem_we_o. done_o=1 and prog_bytes_o=12.
- **Valid gaps:** words separated by 3 idle cycles. Byte addresses stay contiguous, no write occurs while valid is low, and the final prog_bytes_o matches.
- **Overflow, MAX_LINES=8:**
  - Stimulus: send 3 words, none marked last.
  - Response: words 1 and 2 fill bytes 0..7. The third is accepted, with error_o=1 on the accepting edge, no write to address 8, and prog_bytes_o=8.
- **Reset mid-word:** assert rst_i after byte 1 of word 32'hDEADBEEF. No further writes, and wr_ptr/prog_bytes_o return to 0. The next word writes starting at address 0.
